// File: rtl/mult_seq_ctrl_if.sv
// mult_seq_ctrl_if: handshake, operand and result bundle for mult_seq_ctrl
//   start, abort : request / cancel from the master
//   a, b         : N-bit unsigned operands, captured on an accepted start
//   busy, done   : status from the multiplier (done is a one-cycle pulse)
//   product      : 2N-bit result register
interface mult_seq_ctrl_if #(parameter int N = 8);
  logic start;
  logic abort;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic busy;
  logic done;
  logic [2*N-1:0] product;
  modport master (output start, abort, a, b, input busy, done, product);
  modport slave (input start, abort, a, b, output busy, done, product);
endinterface

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequential shift-add unsigned multiplier built around one ripple adder
//   nbit_adder    : a + b + cin -> {cout, s}, ripple carry
//   mult_seq_ctrl : clk, rst_n (async, active-low), bus (slave modport of mult_seq_ctrl_if)
module nbit_adder #(parameter int N = 8) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);
  logic [N:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[N];
endmodule

module mult_seq_ctrl #(parameter int N = 8) (
  input logic          clk,
  input logic          rst_n,
  mult_seq_ctrl_if.slave bus
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [N-1:0] acc_q, acc_d, mq_q, mq_d, mcand_q, mcand_d, sum;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*N-1:0] product_q, product_d;
  logic carry;
  // Gating the addend with MQ[0] yields {0,ACC} when the multiplier bit is clear.
  nbit_adder #(.N(N)) u_add (
    .a(acc_q),
    .b(mq_q[0] ? mcand_q : '0),
    .cin(1'b0),
    .s(sum),
    .cout(carry)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mq_q      <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    if (state_q == IDLE && bus.start) begin
      mcand_d = bus.a;
      mq_d    = bus.b;
      acc_d   = '0;
      cnt_d   = CW'(N);
      state_d = RUN;
    end else if (state_q == RUN) begin
      if (bus.abort) begin
        state_d = IDLE;
      end else begin
        // {ACC,MQ} <= {c,s,MQ[N-1:1]}: the carry lands in ACC[N-1].
        acc_d = {carry, sum[N-1:1]};
        mq_d  = {sum[0], mq_q[N-1:1]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d   = DONE;
          product_d = {acc_d, mq_d};
        end
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  assign bus.busy    = state_q != IDLE;
  assign bus.done    = state_q == DONE;
  assign bus.product = product_q;
endmodule
